// File: rtl/rx_queue_sched.sv
// Receive-side cyclic frame queue slot scheduler: tracks filled slots, steers the
// serial FIFO reader, and covers underrun by replaying a slot and then resyncing.
module rx_queue_sched #(
    parameter int IDX_LEN    = 3,
    parameter int DELAY_CNT  = 0,
    parameter int MISS_LIMIT = 4,
    parameter int CNT_W      = 8
) (
    input  logic               ff_clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_done,
    input  logic [IDX_LEN-1:0] wr_idx,
    input  logic               wr_bad,
    input  logic               rd_req,
    output logic [IDX_LEN-1:0] rd_idx,
    output logic               rd_repeat,
    output logic               rd_resync,
    output logic               start,
    output logic [IDX_LEN:0]   occupancy,
    output logic [CNT_W-1:0]   underrun_cnt,
    output logic [CNT_W-1:0]   overflow_cnt
);
    localparam int DEPTH = 2 ** IDX_LEN;
    localparam int PW    = IDX_LEN + 1;
    localparam int DW    = (DELAY_CNT > 1) ? $clog2(DELAY_CNT) : 1;
    localparam int MW    = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;
    localparam logic [DW-1:0] DLAST = DW'((DELAY_CNT > 0) ? DELAY_CNT - 1 : 0);
    localparam logic [MW-1:0] MLAST = MW'((MISS_LIMIT > 0) ? MISS_LIMIT - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RUN} state_t;

    state_t             r_state,    w_state;
    logic [DEPTH-1:0]   r_vld,      w_vld;
    logic [IDX_LEN-1:0] r_rdIdx,    w_rdIdx;
    logic               r_repeat,   w_repeat;
    logic               r_resync,   w_resync;
    logic               r_start,    w_start;
    logic [PW-1:0]      r_occ;
    logic [CNT_W-1:0]   r_underrun, w_underrun;
    logic [CNT_W-1:0]   r_overflow, w_overflow;
    logic [DW-1:0]      r_delayCnt, w_delayCnt;
    logic [MW-1:0]      r_missCnt,  w_missCnt;

    logic               w_goodWr;
    logic [DEPTH-1:0]   w_wrMask;
    logic [DEPTH-1:0]   w_vldSet;
    logic [IDX_LEN-1:0] w_nxt;
    logic [IDX_LEN-1:0] w_cand;
    logic [IDX_LEN-1:0] w_target;
    logic               w_found;
    logic [PW-1:0]      w_pop;

    assign rd_idx       = r_rdIdx;
    assign rd_repeat    = r_repeat;
    assign rd_resync    = r_resync;
    assign start        = r_start;
    assign occupancy    = r_occ;
    assign underrun_cnt = r_underrun;
    assign overflow_cnt = r_overflow;

    always_comb begin
        w_goodWr = wr_done & ~wr_bad;
        w_wrMask = '0;
        if (w_goodWr) begin
            w_wrMask[wr_idx] = 1'b1;
        end
        w_vldSet = r_vld | w_wrMask;
        w_nxt    = r_rdIdx + 1'b1;
    end

    // Resync target: first filled slot after nxt, wrapping round to just before rd_idx.
    always_comb begin
        w_found  = 1'b0;
        w_target = r_rdIdx;
        w_cand   = r_rdIdx;
        for (int k = 2; k < DEPTH; k++) begin
            w_cand = r_rdIdx + IDX_LEN'(k);
            if (!w_found && w_vldSet[w_cand]) begin
                w_found  = 1'b1;
                w_target = w_cand;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pop = w_pop + PW'(r_vld[i]);
        end
    end

    always_comb begin
        w_state    = r_state;
        w_vld      = w_vldSet;
        w_rdIdx    = r_rdIdx;
        w_repeat   = r_repeat;
        w_resync   = 1'b0;
        w_underrun = r_underrun;
        w_overflow = r_overflow;
        w_delayCnt = r_delayCnt;
        w_missCnt  = r_missCnt;

        if (w_goodWr && r_vld[wr_idx] && (r_overflow != {CNT_W{1'b1}})) begin
            w_overflow = r_overflow + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_goodWr) begin
                    w_rdIdx    = wr_idx;
                    w_delayCnt = '0;
                    w_state    = (DELAY_CNT == 0) ? ST_RUN : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (r_delayCnt == DLAST) begin
                    w_state = ST_RUN;
                end else begin
                    w_delayCnt = r_delayCnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Clearing the finished slot yields to a same-cycle write into it.
                if (rd_req) begin
                    if (w_vldSet[w_nxt]) begin
                        w_vld[r_rdIdx] = w_wrMask[r_rdIdx];
                        w_rdIdx        = w_nxt;
                        w_repeat       = 1'b0;
                        w_missCnt      = '0;
                    end else if ((r_missCnt == MLAST) && w_found) begin
                        w_vld[r_rdIdx] = w_wrMask[r_rdIdx];
                        w_rdIdx        = w_target;
                        w_resync       = 1'b1;
                        w_repeat       = 1'b0;
                        w_missCnt      = '0;
                    end else begin
                        w_repeat = 1'b1;
                        if (r_missCnt != MLAST) begin
                            w_missCnt = r_missCnt + 1'b1;
                        end
                        if (r_underrun != {CNT_W{1'b1}}) begin
                            w_underrun = r_underrun + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_start = (w_state == ST_RUN);
    end

    always_ff @(posedge ff_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge ff_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld      <= '0;
            r_rdIdx    <= '0;
            r_repeat   <= 1'b0;
            r_resync   <= 1'b0;
            r_start    <= 1'b0;
            r_occ      <= '0;
            r_underrun <= '0;
            r_overflow <= '0;
            r_delayCnt <= '0;
            r_missCnt  <= '0;
        end else if (flush) begin
            r_vld      <= '0;
            r_rdIdx    <= '0;
            r_repeat   <= 1'b0;
            r_resync   <= 1'b0;
            r_start    <= 1'b0;
            r_occ      <= '0;
            r_underrun <= '0;
            r_overflow <= '0;
            r_delayCnt <= '0;
            r_missCnt  <= '0;
        end else begin
            r_vld      <= w_vld;
            r_rdIdx    <= w_rdIdx;
            r_repeat   <= w_repeat;
            r_resync   <= w_resync;
            r_start    <= w_start;
            r_occ      <= w_pop;
            r_underrun <= w_underrun;
            r_overflow <= w_overflow;
            r_delayCnt <= w_delayCnt;
            r_missCnt  <= w_missCnt;
        end
    end

endmodule

// File: tb/tb_rx_queue_sched.sv
// Self-checking bench for rx_queue_sched: directed scenarios plus a randomized run
// compared against a slot-list reference model.
module tb_rx_queue_sched;
    localparam int N    = 8;
    localparam int DLY  = 3;
    localparam int MLIM = 4;
    localparam int CMAX = 255;

    logic       ff_clk;
    logic       rst_n;
    logic       flush;
    logic       wr_done;
    logic [2:0] wr_idx;
    logic       wr_bad;
    logic       rd_req;
    logic [2:0] rd_idx;
    logic       rd_repeat;
    logic       rd_resync;
    logic       start;
    logic [3:0] occupancy;
    logic [7:0] underrun_cnt;
    logic [7:0] overflow_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit mVld[N];
    int mRd, mWait, mMiss, mUnder, mOver, mOcc;
    bit mStart, mRep, mResync;

    rx_queue_sched #(.IDX_LEN(3), .DELAY_CNT(DLY), .MISS_LIMIT(MLIM), .CNT_W(8)) dut (
        .ff_clk(ff_clk), .rst_n(rst_n), .flush(flush), .wr_done(wr_done),
        .wr_idx(wr_idx), .wr_bad(wr_bad), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_repeat(rd_repeat), .rd_resync(rd_resync), .start(start),
        .occupancy(occupancy), .underrun_cnt(underrun_cnt), .overflow_cnt(overflow_cnt)
    );

    initial ff_clk = 1'b0;
    always #5 ff_clk = ~ff_clk;

    task automatic modelClear();
        for (int i = 0; i < N; i++) mVld[i] = 0;
        mRd = 0; mWait = -1; mMiss = 0; mUnder = 0; mOver = 0; mOcc = 0;
        mStart = 0; mRep = 0; mResync = 0;
    endtask

    // One clock edge of behaviour; written in terms of the slot list, not FSM states.
    task automatic modelStep(input bit fl, input bit wr, input int wi, input bit wb, input bit req);
        bit good;
        bit avail[N];
        int nxt, target, cnt;
        if (fl) begin
            modelClear();
            return;
        end
        good = wr && !wb;
        cnt = 0;
        for (int i = 0; i < N; i++) if (mVld[i]) cnt++;
        mOcc = cnt;
        mResync = 0;
        if (good && mVld[wi] && mOver < CMAX) mOver++;
        avail = mVld;
        if (good) avail[wi] = 1;
        if (mStart) begin
            if (req) begin
                nxt = (mRd + 1) % N;
                target = -1;
                if (avail[nxt]) begin
                    target = nxt;
                end else if (mMiss == MLIM - 1) begin
                    for (int k = 2; k < N; k++)
                        if (target < 0 && avail[(mRd + k) % N]) target = (mRd + k) % N;
                    if (target >= 0) mResync = 1;
                end
                if (target >= 0) begin
                    mVld[mRd] = 0;
                    mRd = target;
                    mRep = 0;
                    mMiss = 0;
                end else begin
                    mRep = 1;
                    if (mMiss < MLIM - 1) mMiss++;
                    if (mUnder < CMAX) mUnder++;
                end
            end
        end else if (mWait > 0) begin
            mWait--;
            if (mWait == 0) mStart = 1;
        end else if (good) begin
            mRd = wi;
            mWait = DLY;
        end
        if (good) mVld[wi] = 1;
    endtask

    // Drives one cycle of inputs from a negedge, steps the model at the posedge,
    // and returns at the following negedge with inputs idle.
    task automatic applyStimulus(input bit fl, input bit wr, input int wi, input bit wb, input bit req);
        flush = fl; wr_done = wr; wr_idx = 3'(wi); wr_bad = wb; rd_req = req;
        @(posedge ff_clk);
        modelStep(fl, wr, wi, wb, req);
        @(negedge ff_clk);
        flush = 0; wr_done = 0; wr_bad = 0; rd_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        total++; if (rd_idx !== 3'd0) begin bad++; $display("[TB] FAIL reset_rd_idx: got %0d expected 0", rd_idx); end
        total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %0d expected 0", start); end
        total++; if (occupancy !== 4'd0) begin bad++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        total++; if (rd_repeat !== 1'b0 || rd_resync !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: got repeat=%0d resync=%0d expected 0 0", rd_repeat, rd_resync); end
        total++; if (underrun_cnt !== 8'd0 || overflow_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", underrun_cnt, overflow_cnt); end
    endtask

    task automatic test_startup();
        idle(2);
        applyStimulus(0, 1, 5, 0, 0);
        total++; if (rd_idx !== 3'd5) begin bad++; $display("[TB] FAIL startup_rd_idx: got %0d expected 5", rd_idx); end
        total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL startup_start_t0: got %0d expected 0", start); end
        applyStimulus(0, 0, 0, 0, 1);
        total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL startup_start_t1: got %0d expected 0", start); end
        applyStimulus(0, 0, 0, 0, 1);
        total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL startup_start_t2: got %0d expected 0", start); end
        total++; if (rd_idx !== 3'd5 || underrun_cnt !== 8'd0) begin bad++; $display("[TB] FAIL startup_req_ignored: got rd_idx=%0d underrun=%0d expected 5 0", rd_idx, underrun_cnt); end
        idle(1);
        total++; if (start !== 1'b1) begin bad++; $display("[TB] FAIL startup_start_t3: got %0d expected 1", start); end
        total++; if (rd_idx !== 3'd5 || rd_repeat !== 1'b0) begin bad++; $display("[TB] FAIL startup_run: got rd_idx=%0d repeat=%0d expected 5 0", rd_idx, rd_repeat); end
        total++; if (occupancy !== 4'd1) begin bad++; $display("[TB] FAIL startup_occupancy: got %0d expected 1", occupancy); end
    endtask

    task automatic test_advance();
        applyStimulus(0, 1, 6, 0, 0);
        idle(1);
        total++; if (occupancy !== 4'd2) begin bad++; $display("[TB] FAIL advance_occ_before: got %0d expected 2", occupancy); end
        applyStimulus(0, 0, 0, 0, 1);
        total++; if (rd_idx !== 3'd6 || rd_repeat !== 1'b0) begin bad++; $display("[TB] FAIL advance_rd: got rd_idx=%0d repeat=%0d expected 6 0", rd_idx, rd_repeat); end
        idle(1);
        total++; if (occupancy !== 4'd1) begin bad++; $display("[TB] FAIL advance_occ_after: got %0d expected 1", occupancy); end
    endtask

    task automatic test_underrun_resync();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 0, 0);
        applyStimulus(0, 1, 5, 0, 0);
        idle(2);
        total++; if (start !== 1'b1 || rd_idx !== 3'd2) begin bad++; $display("[TB] FAIL resync_setup: got start=%0d rd_idx=%0d expected 1 2", start, rd_idx); end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            total++; if (rd_idx !== 3'd2 || rd_repeat !== 1'b1 || rd_resync !== 1'b0) begin bad++; $display("[TB] FAIL replay_%0d: got rd_idx=%0d repeat=%0d resync=%0d expected 2 1 0", i, rd_idx, rd_repeat, rd_resync); end
        end
        total++; if (underrun_cnt !== 8'd3) begin bad++; $display("[TB] FAIL replay_underrun: got %0d expected 3", underrun_cnt); end
        applyStimulus(0, 0, 0, 0, 1);
        total++; if (rd_idx !== 3'd5 || rd_resync !== 1'b1 || rd_repeat !== 1'b0) begin bad++; $display("[TB] FAIL resync_jump: got rd_idx=%0d resync=%0d repeat=%0d expected 5 1 0", rd_idx, rd_resync, rd_repeat); end
        total++; if (underrun_cnt !== 8'd3) begin bad++; $display("[TB] FAIL resync_underrun: got %0d expected 3", underrun_cnt); end
        idle(1);
        total++; if (rd_resync !== 1'b0 || occupancy !== 4'd1) begin bad++; $display("[TB] FAIL resync_pulse_end: got resync=%0d occ=%0d expected 0 1", rd_resync, occupancy); end
    endtask

    task automatic test_overflow_bad();
        applyStimulus(0, 1, 3, 0, 0);
        applyStimulus(0, 1, 3, 0, 0);
        total++; if (overflow_cnt !== 8'd1) begin bad++; $display("[TB] FAIL overflow_cnt: got %0d expected 1", overflow_cnt); end
        idle(2);
        total++; if (occupancy !== 4'd2) begin bad++; $display("[TB] FAIL overflow_occ: got %0d expected 2", occupancy); end
        applyStimulus(0, 1, 4, 1, 0);
        idle(2);
        total++; if (occupancy !== 4'd2 || overflow_cnt !== 8'd1) begin bad++; $display("[TB] FAIL bad_write_ignored: got occ=%0d ovf=%0d expected 2 1", occupancy, overflow_cnt); end
        applyStimulus(0, 1, 6, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        total++; if (rd_idx !== 3'd5 || rd_repeat !== 1'b1 || underrun_cnt !== 8'd4) begin bad++; $display("[TB] FAIL bad_write_no_advance: got rd_idx=%0d repeat=%0d underrun=%0d expected 5 1 4", rd_idx, rd_repeat, underrun_cnt); end
    endtask

    task automatic test_simultaneous();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 0, 0);
        idle(3);
        total++; if (start !== 1'b1 || rd_idx !== 3'd7) begin bad++; $display("[TB] FAIL simul_setup: got start=%0d rd_idx=%0d expected 1 7", start, rd_idx); end
        applyStimulus(0, 1, 0, 0, 1);
        total++; if (rd_idx !== 3'd0 || rd_repeat !== 1'b0 || underrun_cnt !== 8'd0) begin bad++; $display("[TB] FAIL simul_wrap: got rd_idx=%0d repeat=%0d underrun=%0d expected 0 0 0", rd_idx, rd_repeat, underrun_cnt); end
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        total++; if (rd_idx !== 3'd1 || overflow_cnt !== 8'd1) begin bad++; $display("[TB] FAIL simul_clear_write: got rd_idx=%0d ovf=%0d expected 1 1", rd_idx, overflow_cnt); end
        idle(2);
        total++; if (occupancy !== 4'd2) begin bad++; $display("[TB] FAIL simul_write_wins: got occ=%0d expected 2", occupancy); end
    endtask

    task automatic test_flush();
        applyStimulus(0, 0, 0, 0, 1);
        total++; if (underrun_cnt !== 8'd1) begin bad++; $display("[TB] FAIL flush_pre_underrun: got %0d expected 1", underrun_cnt); end
        applyStimulus(1, 1, 2, 0, 1);
        total++; if (start !== 1'b0 || occupancy !== 4'd0 || rd_idx !== 3'd0) begin bad++; $display("[TB] FAIL flush_state: got start=%0d occ=%0d rd_idx=%0d expected 0 0 0", start, occupancy, rd_idx); end
        total++; if (underrun_cnt !== 8'd0 || overflow_cnt !== 8'd0) begin bad++; $display("[TB] FAIL flush_counters: got %0d/%0d expected 0/0", underrun_cnt, overflow_cnt); end
    endtask

    task automatic test_saturation();
        applyStimulus(0, 1, 3, 0, 0);
        idle(3);
        for (int i = 0; i < 260; i++) applyStimulus(0, 0, 0, 0, 1);
        total++; if (underrun_cnt !== 8'd255) begin bad++; $display("[TB] FAIL underrun_saturate: got %0d expected 255", underrun_cnt); end
        total++; if (rd_idx !== 3'd3 || rd_repeat !== 1'b1 || start !== 1'b1) begin bad++; $display("[TB] FAIL starve_hold: got rd_idx=%0d repeat=%0d start=%0d expected 3 1 1", rd_idx, rd_repeat, start); end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (start !== 1'b0 || rd_idx !== 3'd0 || rd_repeat !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_ctrl: got start=%0d rd_idx=%0d repeat=%0d expected 0 0 0", start, rd_idx, rd_repeat); end
        total++; if (underrun_cnt !== 8'd0 || occupancy !== 4'd0) begin bad++; $display("[TB] FAIL async_reset_stats: got underrun=%0d occ=%0d expected 0 0", underrun_cnt, occupancy); end
        @(negedge ff_clk);
        rst_n = 1'b1;
        modelClear();
    endtask

    task automatic test_random();
        int r;
        applyStimulus(1, 0, 0, 0, 0);
        for (int c = 0; c < 500; c++) begin
            r = $urandom_range(0, 99);
            if (r < 2) applyStimulus(1, 0, 0, 0, 0);
            else if (r < 45) applyStimulus(0, 1, $urandom_range(0, 7), ($urandom_range(0, 3) == 0), 0);
            else if (r < 85) applyStimulus(0, 0, 0, 0, 1);
            else applyStimulus(0, 0, 0, 0, 0);
            total++; if (rd_idx !== 3'(mRd)) begin bad++; $display("[TB] FAIL rand_rd_idx c=%0d: got %0d expected %0d", c, rd_idx, mRd); end
            total++; if (rd_repeat !== mRep) begin bad++; $display("[TB] FAIL rand_repeat c=%0d: got %0d expected %0d", c, rd_repeat, mRep); end
            total++; if (rd_resync !== mResync) begin bad++; $display("[TB] FAIL rand_resync c=%0d: got %0d expected %0d", c, rd_resync, mResync); end
            total++; if (start !== mStart) begin bad++; $display("[TB] FAIL rand_start c=%0d: got %0d expected %0d", c, start, mStart); end
            total++; if (occupancy !== 4'(mOcc)) begin bad++; $display("[TB] FAIL rand_occupancy c=%0d: got %0d expected %0d", c, occupancy, mOcc); end
            total++; if (underrun_cnt !== 8'(mUnder)) begin bad++; $display("[TB] FAIL rand_underrun c=%0d: got %0d expected %0d", c, underrun_cnt, mUnder); end
            total++; if (overflow_cnt !== 8'(mOver)) begin bad++; $display("[TB] FAIL rand_overflow c=%0d: got %0d expected %0d", c, overflow_cnt, mOver); end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; wr_done = 0; wr_idx = 0; wr_bad = 0; rd_req = 0;
        modelClear();
        @(negedge ff_clk);
        @(negedge ff_clk);
        test_reset();
        rst_n = 1'b1;
        test_startup();
        test_advance();
        test_underrun_resync();
        test_overflow_bad();
        test_simultaneous();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
